// File: rtl/jt51_host_pkg.sv
// jt51_host_pkg: shared FSM encoding and status bit index for the jt51 host writer
package jt51_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_WR,
      ADDR_WAIT,
      DATA_WR,
      DATA_WAIT
   } state_t;

   localparam int BUSY_BIT = 7;

   function automatic logic is_strobe(input state_t s);
      return (s == ADDR_WR) || (s == DATA_WR);
   endfunction

endpackage

// File: rtl/jt51_host_fifo.sv
// jt51_host_fifo: power-of-two request FIFO with occupancy output, head is read combinationally
module jt51_host_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;

   // storage needs no reset: reset empties the FIFO through the pointers and level
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

   assign dout  = mem[rp];
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/jt51_host_wr.sv
// jt51_host_wr: queues YM2151 register writes and plays them onto the jt51 bus with busy polling
module jt51_host_wr
   import jt51_host_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GUARD      = 2,
   parameter int TIMEOUT    = 1023
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [7:0]                    req_addr,
   input  logic [7:0]                    req_data,
   output logic                          cs_n,
   output logic                          wr_n,
   output logic                          a0,
   output logic [7:0]                    dout,
   input  logic [7:0]                    status_in,
   output logic                          idle,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          err,
   input  logic                          err_clr
);

   localparam int PW = $clog2(TIMEOUT + 1);
   localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

   state_t         state;
   state_t         nxt;
   logic [15:0]    head;
   logic [PW-1:0]  pc;
   logic [GW-1:0]  gc;
   logic           waiting;
   logic           polled;
   logic           busy;
   logic           tmo;
   logic           go;
   logic           pop;
   logic           push;
   logic           full;
   logic           empty;
   logic           unused_status;

   assign unused_status = ^status_in;
   assign push      = req_valid && req_ready;
   assign req_ready = !full;
   assign idle      = empty && (state == IDLE);

   jt51_host_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({req_addr, req_data}),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // next state: the guard window ignores status, then busy is polled until clear or timeout
   always_comb begin
      nxt     = state;
      waiting = (state == ADDR_WAIT) || (state == DATA_WAIT);
      polled  = waiting && (gc == GW'(GUARD));
      busy    = status_in[BUSY_BIT];
      tmo     = polled && busy && (pc == PW'(TIMEOUT - 1));
      go      = polled && (!busy || tmo);
      pop     = (state == DATA_WAIT) && go;
      case (state)
         IDLE:      nxt = empty ? IDLE : ADDR_WR;
         ADDR_WR:   nxt = ADDR_WAIT;
         ADDR_WAIT: nxt = go ? DATA_WR : ADDR_WAIT;
         DATA_WR:   nxt = DATA_WAIT;
         DATA_WAIT: nxt = go ? IDLE : DATA_WAIT;
         default:   nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // guard and poll counters restart on every state entry; poll count saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gc <= '0;
         pc <= '0;
      end else if (nxt != state) begin
         gc <= '0;
         pc <= '0;
      end else if (waiting) begin
         if (!polled)                gc <= gc + GW'(1);
         else if (pc != {PW{1'b1}})  pc <= pc + PW'(1);
      end
   end

   // bus outputs registered from the next state so a strobe lines up exactly with its state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_n <= 1'b1;
         wr_n <= 1'b1;
         a0   <= 1'b0;
         dout <= 8'h00;
      end else begin
         cs_n <= !is_strobe(nxt);
         wr_n <= !is_strobe(nxt);
         a0   <= (nxt == DATA_WR);
         dout <= (nxt == ADDR_WR) ? head[15:8] : (nxt == DATA_WR) ? head[7:0] : 8'h00;
      end
   end

   // sticky timeout flag; a timeout in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err <= 1'b0;
      else if (tmo)     err <= 1'b1;
      else if (err_clr) err <= 1'b0;
   end

endmodule

// File: doc/jt51_host_wr.md
JT51_HOST_WR -- requirements
Module: jt51_host_wr

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request FIFO entries; power of two, at least 2.
REQ-002 Parameter GUARD, default 2, clk cycles after each strobe during which status_in is ignored.
REQ-003 Parameter TIMEOUT, default 1023, maximum busy-poll cycles before forced continue.
REQ-004 clk  input  1  clock (jt51 main clk domain).
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  register-write request present.
REQ-007 req_ready  output  1  FIFO not full; a request is accepted when req_valid and req_ready are both high at a clk edge.
REQ-008 req_addr  input  8  YM2151 register address.
REQ-009 req_data  input  8  YM2151 register data.
REQ-010 cs_n  output  1  chip select to jt51, active-low.
REQ-011 wr_n  output  1  write strobe to jt51, active-low.
REQ-012 a0  output  1  0 selects the address port, 1 selects the data port.
REQ-013 dout  output  8  bus data to jt51 d_in.
REQ-014 status_in  input  8  jt51 d_out; bit 7 is busy.
REQ-015 idle  output  1  high when the FIFO is empty and the FSM is in IDLE.
REQ-016 level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 err  output  1  sticky busy-timeout flag.
REQ-018 err_clr  input  1  clears err.

Function
REQ-019 All bus outputs (cs_n, wr_n, a0, dout) shall be registered; the idle bus value is cs_n=1, wr_n=1, a0=0, dout=0x00.
REQ-020 The FIFO shall be first-in first-out, FIFO_DEPTH x 16 bits, storing {addr,data}; req_ready = (level != FIFO_DEPTH).
REQ-021 A push on a full FIFO is impossible because req_ready is low; a pop and a push in the same cycle shall leave level unchanged.
REQ-022 FSM states: IDLE, ADDR_WR, ADDR_WAIT, DATA_WR, DATA_WAIT.
REQ-023 IDLE -> ADDR_WR at the first edge where level > 0; a request accepted at edge N shall produce its strobe from edge N+1 to edge N+2.
REQ-024 ADDR_WR shall last exactly 1 clk with cs_n=0, wr_n=0, a0=0, dout=head.addr, then go to ADDR_WAIT.
REQ-025 WAIT states shall first count GUARD cycles with status_in ignored, then poll status_in[7] every cycle.
REQ-026 ADDR_WAIT -> DATA_WR on the first polled cycle with status_in[7]=0.
REQ-027 DATA_WR shall last exactly 1 clk with cs_n=0, wr_n=0, a0=1, dout=head.data, then go to DATA_WAIT.
REQ-028 DATA_WAIT -> IDLE on the first polled cycle with status_in[7]=0; the head entry shall be popped on that transition edge.
REQ-029 Outside ADDR_WR and DATA_WR, cs_n and wr_n shall be 1, so there is never more than one strobe cycle per port write.
REQ-030 Timeout: if the poll count reaches TIMEOUT with status_in[7]=1, the FSM shall set err=1 and take the not-busy transition.
REQ-031 The poll counter shall be width clog2(TIMEOUT+1), shall saturate, and shall clear on every state entry.
REQ-032 When err_clr and a timeout occur in the same cycle, err shall end at 1 (set wins).
REQ-033 A back-to-back queue shall be drained with IDLE occupying 1 cycle between entries.
REQ-034 The FIFO pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-035 While rst is high: FSM=IDLE, FIFO empty (level=0), req_ready=1, idle=1, err=0, bus outputs at idle values, counters 0.
REQ-036 A reset asserted mid-transaction shall abort it immediately (asynchronously) and discard queued entries; no partial strobe shall persist after rst rises.

Structure
REQ-037 FSM state encoding and status bit index BUSY_BIT=7 shall live in shared package jt51_host_pkg.
REQ-038 The FIFO shall be a separate sub-module, jt51_host_fifo (parameterised depth and width, with level output).

Verification
REQ-039 Single write addr=0x14, data=0x35, busy model high 3 cycles after each strobe -> exactly two strobes: a0=0/dout=0x14, then a0=1/dout=0x35; pop; idle=1; err=0.
REQ-040 Push 4 requests back-to-back with FIFO_DEPTH=4 -> req_ready low after the 4th; the 5th is held until the first pop; order is preserved across pointer wrap.
REQ-041 status_in[7] held at 1 -> err=1 after GUARD+TIMEOUT cycles in ADDR_WAIT, the data strobe still issues; err_clr pulse -> err=0.
REQ-042 Busy already low during the guard window (glitch at 1) -> status is ignored and the transition occurs exactly at GUARD+1 cycles after the strobe.
REQ-043 Assert rst during DATA_WR with 2 entries queued -> cs_n=1 and wr_n=1 immediately, level=0, no further strobes after release.
REQ-044 Integration: drive jt51 and write 0x20 <- 0xC7 -> jt51 rl_I/con_I for channel 0 reflect 0xC7, and the busy handshake completes with err=0.
